hilo_unit: RTL

- Owns the HI/LO architectural registers for the MIPS-style core.
- Sits in EX, directly upstream of the multi-cycle divider: it registers operands, pulses the divider start, waits out the divider's busy window, then writes quotient/remainder into LO/HI.
- Also performs MULT/MULTU with an internal two-cycle multiply path, and MTHI/MTLO writes.
- Drives a stall signal so HI/LO consumers (MFHI/MFLO, later mul/div) hold until the result has landed.

---
 rtl/hilo_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register owner with multiply path and divider sequencing
module hilo_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_flush,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_stall,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  output logic        o_div_is_unsigned,
  output logic        o_div_start,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  input  logic        i_div_busy
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  if (DIV_CYCLES < 1) begin : g_bad_div_cycles
    $error("hilo_unit: DIV_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    MUL_CALC,
    MUL_WB,
    DIV_ISSUE,
    DIV_WAIT
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        div_done;
  logic [63:0] mul_a, mul_b;
  logic [63:0] product;
  logic [31:0] hi, lo;

  assign accept   = (state == IDLE) && i_op_valid && !i_flush;
  assign is_mul   = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign is_div   = ((i_op == OP_DIV) || (i_op == OP_DIVU)) && (i_rt_data != 32'd0);
  assign div_done = (state == DIV_WAIT) && !i_div_busy && !i_flush;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL_CALC;
        else if (accept && is_div) state_next = DIV_ISSUE;
      end
      MUL_CALC:  state_next = i_flush ? IDLE : MUL_WB;
      MUL_WB:    state_next = IDLE;
      DIV_ISSUE: state_next = i_flush ? IDLE : DIV_WAIT;
      DIV_WAIT:  state_next = (i_flush || !i_div_busy) ? IDLE : DIV_WAIT;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Both operands are extended to 64 bits so the truncated product is exact for either signedness.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_a   <= '0;
      mul_b   <= '0;
      product <= '0;
    end else begin
      if (accept && is_mul) begin
        mul_a <= (i_op == OP_MULT) ? {{32{i_rs_data[31]}}, i_rs_data} : {32'd0, i_rs_data};
        mul_b <= (i_op == OP_MULT) ? {{32{i_rt_data[31]}}, i_rt_data} : {32'd0, i_rt_data};
      end
      if (state == MUL_CALC) product <= mul_a * mul_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_div_dividend    <= '0;
      o_div_divisor     <= '0;
      o_div_is_unsigned <= 1'b0;
    end else if (accept && is_div) begin
      o_div_dividend    <= i_rs_data;
      o_div_divisor     <= i_rt_data;
      o_div_is_unsigned <= (i_op == OP_DIVU);
    end
  end

  // A flush in MUL_WB or on the busy-drop cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept && (i_op == OP_MTHI)) hi <= i_rs_data;
      if (accept && (i_op == OP_MTLO)) lo <= i_rs_data;
      if ((state == MUL_WB) && !i_flush) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
      if (div_done) begin
        hi <= i_div_remainder;
        lo <= i_div_quotient;
      end
    end
  end

  assign o_hi        = hi;
  assign o_lo        = lo;
  assign o_stall     = (state != IDLE);
  assign o_div_start = (state == DIV_ISSUE);

endmodule
